line_buffer2uart_fifo: RTL and testbench

//  Transmit-side counterpart of the UART RX-FIFO-to-line-buffer importer.

---
 rtl/line_buffer2uart_fifo.sv | 128 ++++++++++++
 tb/tb_line_buffer2uart_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer2uart_fifo.sv
// line_buffer2uart_fifo
// Streams processed image lines, one byte per clock, from a synchronous-read
// line buffer into the UART TX FIFO. A line is only started once the FIFO has
// room for all of it, so the free count is never consulted mid-line.
// Optional feature: define LB2TX_LINE_MARKER_EN to append a 8'h0A byte after
// every line (one extra FIFO byte is then reserved per line).
module line_buffer2uart_fifo #(
  parameter int LINE_WIDTH = 512,
  parameter int NUM_LINES  = 512,
  parameter int ADDR_W     = 9,
  parameter int LCNT_W     = 9,
  parameter int FREE_W     = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_ready,
  input  logic [FREE_W-1:0] tx_fifo_free,
  input  logic [7:0]        lb_rd_data,
  output logic              lb_rd_en,
  output logic [ADDR_W-1:0] lb_rd_addr,
  output logic              tx_wr_en,
  output logic [7:0]        tx_wr_data,
  output logic              line_ack,
  output logic [LCNT_W-1:0] line_counter,
  output logic              frame_done,
  output logic              busy
);

`ifdef LB2TX_LINE_MARKER_EN
  localparam int NEED_INT = LINE_WIDTH + 1;
`else
  localparam int NEED_INT = LINE_WIDTH;
`endif

  // One extra bit so NEED always fits even when it equals 2**FREE_W - 1 + 1.
  localparam logic [FREE_W:0]   NEED      = (FREE_W+1)'(NEED_INT);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(LINE_WIDTH - 1);
  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(NUM_LINES - 1);
  localparam logic [7:0]        MARKER    = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_MARK,
    S_ACK
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] byte_cnt;
  logic              rd_en_d;

  // State register; reset drops any line in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and all outputs; the write side replays the read enable one clock late.
  always_comb begin
    next_state = state;
    lb_rd_en   = 1'b0;
    lb_rd_addr = '0;
    line_ack   = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    tx_wr_en   = rd_en_d;
    tx_wr_data = rd_en_d ? lb_rd_data : 8'h00;
    case (state)
      S_IDLE: begin
        if (line_ready && ({1'b0, tx_fifo_free} >= NEED)) begin
          next_state = S_READ;
        end
      end
      S_READ: begin
        lb_rd_en   = 1'b1;
        lb_rd_addr = byte_cnt;
        if (byte_cnt == LAST_BYTE) begin
          next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
`ifdef LB2TX_LINE_MARKER_EN
        next_state = S_MARK;
`else
        next_state = S_ACK;
`endif
      end
      S_MARK: begin
        tx_wr_en   = 1'b1;
        tx_wr_data = MARKER;
        next_state = S_ACK;
      end
      S_ACK: begin
        line_ack   = 1'b1;
        frame_done = (line_counter == LAST_LINE);
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Byte address, line index and the one-stage read-to-write delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt     <= '0;
      line_counter <= '0;
      rd_en_d      <= 1'b0;
    end else begin
      rd_en_d <= lb_rd_en;
      if (state == S_IDLE) begin
        byte_cnt <= '0;
      end else if (state == S_READ) begin
        byte_cnt <= byte_cnt + ADDR_W'(1);
      end
      if (state == S_ACK) begin
        line_counter <= (line_counter == LAST_LINE) ? '0 : line_counter + LCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_buffer2uart_fifo.sv
// tb_line_buffer2uart_fifo
// Bench for line_buffer2uart_fifo at LINE_WIDTH=8, NUM_LINES=4. A cycle-offset
// reference model derived from the documented latencies tracks every line,
// and a TX FIFO occupancy model guards against overfilling.
// Honors LB2TX_LINE_MARKER_EN when the build defines it.
module tb_line_buffer2uart_fifo;

  localparam int LW  = 8;
  localparam int NL  = 4;
  localparam int AW  = 4;
  localparam int LCW = 3;
  localparam int FW  = 14;
`ifdef LB2TX_LINE_MARKER_EN
  localparam int MARK = 1;
`else
  localparam int MARK = 0;
`endif
  localparam int NEED   = LW + MARK;
  localparam int ACK_K  = LW + 2 + MARK;
  localparam int PERIOD = ACK_K + 1;
  localparam int CAP    = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           line_ready = 1'b0;
  logic [FW-1:0]  tx_fifo_free = '0;
  logic [7:0]     lb_rd_data = '0;
  logic           lb_rd_en;
  logic [AW-1:0]  lb_rd_addr;
  logic           tx_wr_en;
  logic [7:0]     tx_wr_data;
  logic           line_ack;
  logic [LCW-1:0] line_counter;
  logic           frame_done;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  bit model_busy = 1'b0;
  bit directed = 1'b1;
  int k = 0;
  int model_line = 0;
  int occ = 0;
  int frame_bytes = 0;
  int wr_total = 0;
  int rd_total = 0;
  int frames = 0;

  line_buffer2uart_fifo #(
    .LINE_WIDTH(LW),
    .NUM_LINES (NL),
    .ADDR_W    (AW),
    .LCNT_W    (LCW),
    .FREE_W    (FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .line_ready  (line_ready),
    .tx_fifo_free(tx_fifo_free),
    .lb_rd_data  (lb_rd_data),
    .lb_rd_en    (lb_rd_en),
    .lb_rd_addr  (lb_rd_addr),
    .tx_wr_en    (tx_wr_en),
    .tx_wr_data  (tx_wr_data),
    .line_ack    (line_ack),
    .line_counter(line_counter),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read line buffer holding byte = addr + 16*line.
  always @(posedge clk) begin
    if (lb_rd_en) begin
      lb_rd_data <= 8'(32'(lb_rd_addr) + 16 * 32'(line_counter));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input int free, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      line_ready   = rdy;
      tx_fifo_free = FW'(free);
    end
  endtask

  task automatic doReset();
    reset      = 1'b1;
    line_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Reference model: cycle offset k since the sampled start decides every output.
  always @(negedge clk) begin
    bit exp_rd;
    bit exp_wr;
    bit exp_ack;
    int exp_data;
    if (reset) begin
      model_busy  = 1'b0;
      k           = 0;
      model_line  = 0;
      frame_bytes = 0;
      checkOutput("rst_outs", 32'({lb_rd_en, tx_wr_en, line_ack, frame_done, busy}), 32'd0);
      checkOutput("rst_lcnt", 32'(line_counter), 32'd0);
      checkOutput("rst_addr", 32'(lb_rd_addr), 32'd0);
    end else begin
      if (directed) begin
        occ = 0;
      end else if (occ > 0 && $urandom_range(0, 1) == 1) begin
        occ--;
      end
      if (model_busy) k++;
      exp_rd  = model_busy && k >= 1 && k <= LW;
      exp_wr  = model_busy && k >= 2 && k <= LW + 1 + MARK;
      exp_ack = model_busy && k == ACK_K;
      checkOutput("busy", 32'(busy), 32'(model_busy));
      checkOutput("rd_en", 32'(lb_rd_en), 32'(exp_rd));
      if (exp_rd) checkOutput("rd_addr", 32'(lb_rd_addr), 32'(k - 1));
      checkOutput("wr_en", 32'(tx_wr_en), 32'(exp_wr));
      if (exp_wr) begin
        exp_data = (k <= LW + 1) ? ((k - 2 + 16 * model_line) % 256) : 32'h0A;
        checkOutput("wr_data", 32'(tx_wr_data), 32'(exp_data));
      end
      checkOutput("line_ack", 32'(line_ack), 32'(exp_ack));
      checkOutput("frame_done", 32'(frame_done), 32'(exp_ack && model_line == NL - 1));
      checkOutput("line_counter", 32'(line_counter), 32'(model_line));
      if (tx_wr_en) begin
        checkOutput("fifo_room", 32'(occ < CAP), 32'd1);
        occ++;
        frame_bytes++;
        wr_total++;
      end
      if (lb_rd_en) rd_total++;
      if (frame_done) begin
        checkOutput("frame_bytes", 32'(frame_bytes), 32'(NL * (LW + MARK)));
        frame_bytes = 0;
        frames++;
      end
      if (exp_ack) begin
        model_busy = 1'b0;
        model_line = (model_line + 1) % NL;
      end else if (!model_busy && line_ready && 32'(tx_fifo_free) >= NEED) begin
        model_busy = 1'b1;
        k = 0;
      end
    end
  end

  // Directed scenarios followed by a randomized FIFO backpressure run.
  initial begin
    int wr0;
    int rd0;
    int fr0;
    bit found;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_lcnt", 32'(line_counter), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // single line from reset
    wr0 = wr_total;
    applyStimulus(1'b1, NEED, 1);
    applyStimulus(1'b0, NEED, PERIOD + 3);
    checkOutput("t1_writes", 32'(wr_total - wr0), 32'(LW + MARK));
    checkOutput("t1_lcnt", 32'(line_counter), 32'd1);

    // one byte short of room: must stall, then start once room appears
    rd0 = rd_total;
    wr0 = wr_total;
    applyStimulus(1'b1, NEED - 1, 20);
    checkOutput("stall_rd", 32'(rd_total - rd0), 32'd0);
    checkOutput("stall_wr", 32'(wr_total - wr0), 32'd0);
    checkOutput("stall_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, NEED, 1);
    applyStimulus(1'b0, NEED, PERIOD + 3);
    checkOutput("stall_lcnt", 32'(line_counter), 32'd2);

    // four back-to-back lines, exactly one frame
    doReset();
    wr0 = wr_total;
    fr0 = frames;
    applyStimulus(1'b1, NEED, 4 * PERIOD - 1);
    applyStimulus(1'b0, NEED, 10);
    checkOutput("b2b_writes", 32'(wr_total - wr0), 32'(4 * (LW + MARK)));
    checkOutput("b2b_frames", 32'(frames - fr0), 32'd1);
    checkOutput("b2b_lcnt", 32'(line_counter), 32'd0);

    // reset at byte 4 of line 2, then restart from line 0
    doReset();
    line_ready   = 1'b1;
    tx_fifo_free = FW'(NEED);
    found = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !found; i++) begin
      @(negedge clk);
      #1;
      if (lb_rd_en && lb_rd_addr == AW'(4) && line_counter == LCW'(2)) found = 1'b1;
    end
    checkOutput("abort_reach", 32'(found), 32'd1);
    reset      = 1'b1;
    line_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("abort_outs", 32'({lb_rd_en, tx_wr_en, line_ack, frame_done, busy}), 32'd0);
    checkOutput("abort_lcnt", 32'(line_counter), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    wr0 = wr_total;
    applyStimulus(1'b1, NEED, 1);
    applyStimulus(1'b0, NEED, PERIOD + 3);
    checkOutput("restart_writes", 32'(wr_total - wr0), 32'(LW + MARK));
    checkOutput("restart_lcnt", 32'(line_counter), 32'd1);

    // randomized line_ready and FIFO drain with an accurate free count
    doReset();
    @(negedge clk);
    directed = 1'b0;
    fr0 = frames;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #2;
      line_ready   = ($urandom_range(0, 3) != 0);
      tx_fifo_free = FW'(CAP - occ);
    end
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(posedge clk);
      #2;
      line_ready   = 1'b0;
      tx_fifo_free = FW'(CAP - occ);
    end
    checkOutput("rand_frames", 32'(frames > fr0), 32'd1);
    checkOutput("rand_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
